ptp_offset_calc: RTL and testbench



---
 rtl/ptp_offset_calc_if.sv | 16 +
 rtl/ptp_offset_calc.sv | 130 +++++++++++++
 tb/tb_ptp_offset_calc.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ptp_offset_calc_if.sv
// ptp_offset_calc_if: timestamp events in, offset/delay results out
//   master: drives timer, ts_2_record, ts_1_valid/ts_1, ts_3_record, ts_4_valid/ts_4
//   slave : drives offset_valid, offset, delay, sync_err, sync_count
interface ptp_offset_calc_if #(parameter int W_TS = 48);
  logic [W_TS-1:0] timer, ts_1, ts_4, offset, delay;
  logic ts_2_record, ts_1_valid, ts_3_record, ts_4_valid, offset_valid, sync_err;
  logic [31:0] sync_count;
  modport master(
    output timer, ts_2_record, ts_1_valid, ts_1, ts_3_record, ts_4_valid, ts_4,
    input offset_valid, offset, delay, sync_err, sync_count
  );
  modport slave(
    input timer, ts_2_record, ts_1_valid, ts_1, ts_3_record, ts_4_valid, ts_4,
    output offset_valid, offset, delay, sync_err, sync_count
  );
endinterface

// File: rtl/ptp_offset_calc.sv
// ptp_offset_calc: assembles T1..T4 per Sync and computes slave offset and mean path delay
//   clk, reset : clock, asynchronous active-high reset
//   bus        : event inputs (timer, T1/T2/T3/T4 marks) and results (offset, delay, sync_err, sync_count)
module ptp_offset_calc #(
  parameter int W_TS    = 48,
  parameter int NS_WRAP = 125000,
  parameter int TIMEOUT = 1250000
) (
  input logic clk,
  input logic reset,
  ptp_offset_calc_if.slave bus
);
  localparam int LO_W = 17;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_T1, WAIT_T3, WAIT_T4} state_t;
  state_t state_q, state_d, state_ev;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [W_TS-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic [3:0][W_TS-1:0] p0_q, p0_d, p1_q, p1_d;
  logic p0_v_q, p0_v_d, p1_v_q, p1_v_d, p2_v_q, p2_v_d;
  logic [W_TS:0] a_q, a_d, b_q, b_d;
  logic [W_TS+1:0] sum, diff;
  logic [W_TS-1:0] offset_q, offset_d, delay_q, delay_d;
  logic offset_valid_q, offset_valid_d, sync_err_q, sync_err_d;
  logic [31:0] sync_count_q, sync_count_d;
  logic fsm_err, hand, timeout, ok, rej;
  function automatic logic [W_TS-1:0] lin(input logic [W_TS-1:0] t);
    return W_TS'(t[W_TS-1:LO_W]) * W_TS'(NS_WRAP) + W_TS'(t[LO_W-1:0]);
  endfunction
  always_comb begin
    state_ev = state_q;
    t1_d = t1_q;
    t2_d = t2_q;
    t3_d = t3_q;
    fsm_err = 1'b0;
    hand = 1'b0;
    case (state_q)
      IDLE: if (bus.ts_2_record) begin
        t2_d = bus.timer;
        state_ev = WAIT_T1;
      end
      WAIT_T1: if (bus.ts_1_valid) begin
        t1_d = bus.ts_1;
        state_ev = WAIT_T3;
      end else if (bus.ts_2_record) t2_d = bus.timer;
      WAIT_T3: if (bus.ts_2_record) begin
        fsm_err = 1'b1;
        t2_d = bus.timer;
        state_ev = WAIT_T1;
      end else if (bus.ts_3_record) begin
        t3_d = bus.timer;
        state_ev = WAIT_T4;
      end
      WAIT_T4: if (bus.ts_4_valid) begin
        hand = 1'b1;
        t2_d = bus.ts_2_record ? bus.timer : t2_q;
        state_ev = bus.ts_2_record ? WAIT_T1 : IDLE;
      end else if (bus.ts_2_record) begin
        fsm_err = 1'b1;
        t2_d = bus.timer;
        state_ev = WAIT_T1;
      end
    endcase
    // An event that moves the FSM this cycle wins over an expiring watchdog.
    timeout = state_q != IDLE && state_ev == state_q && wd_q == WD_W'(TIMEOUT - 1);
    state_d = timeout ? IDLE : state_ev;
    wd_d = (state_d != state_q || state_q == IDLE) ? '0 : wd_q + 1'b1;
    // Raw stage loads every cycle; only the valid bit qualifies it.
    p0_v_d = hand;
    p0_d = {bus.ts_4, t3_q, t2_q, t1_q};
    p1_v_d = p0_v_q;
    for (int i = 0; i < 4; i++) p1_d[i] = lin(p0_q[i]);
    p2_v_d = p1_v_q;
    a_d = {1'b0, p1_q[1]} - {1'b0, p1_q[0]};
    b_d = {1'b0, p1_q[3]} - {1'b0, p1_q[2]};
    // One extra bit keeps A+B and A-B exact; dropping bit 0 is the floor halving.
    sum = {a_q[W_TS], a_q} + {b_q[W_TS], b_q};
    diff = {a_q[W_TS], a_q} - {b_q[W_TS], b_q};
    ok = p2_v_q & ~sum[W_TS+1];
    rej = p2_v_q & sum[W_TS+1];
    offset_d = ok ? diff[W_TS:1] : offset_q;
    delay_d = ok ? sum[W_TS:1] : delay_q;
    offset_valid_d = ok;
    sync_err_d = fsm_err | timeout | rej;
    sync_count_d = sync_count_q + 32'(ok);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wd_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      t3_q <= '0;
      p0_q <= '0;
      p1_q <= '0;
      p0_v_q <= 1'b0;
      p1_v_q <= 1'b0;
      p2_v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      offset_q <= '0;
      delay_q <= '0;
      offset_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
      sync_count_q <= '0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      t3_q <= t3_d;
      p0_q <= p0_d;
      p1_q <= p1_d;
      p0_v_q <= p0_v_d;
      p1_v_q <= p1_v_d;
      p2_v_q <= p2_v_d;
      a_q <= a_d;
      b_q <= b_d;
      offset_q <= offset_d;
      delay_q <= delay_d;
      offset_valid_q <= offset_valid_d;
      sync_err_q <= sync_err_d;
      sync_count_q <= sync_count_d;
    end
  assign bus.offset_valid = offset_valid_q;
  assign bus.offset = offset_q;
  assign bus.delay = delay_q;
  assign bus.sync_err = sync_err_q;
  assign bus.sync_count = sync_count_q;
endmodule

// File: tb/tb_ptp_offset_calc.sv
// tb_ptp_offset_calc: directed and randomized exchanges checked against an arithmetic model
module tb_ptp_offset_calc;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  int unsigned rbase = 1000;
  ptp_offset_calc_if bus();
  ptp_offset_calc #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [47:0] ts(input int hi, input int lo);
    return {hi[30:0], lo[16:0]};
  endfunction
  function automatic logic [47:0] rnd_ts(input int k);
    logic [30:0] h;
    logic [16:0] l;
    h = (k % 2 == 1) ? 31'($urandom) : 31'(rbase + $urandom_range(0, 1));
    l = 17'($urandom_range(0, 124999));
    return {h, l};
  endfunction
  function automatic void model(input logic [47:0] t1, t2, t3, t4,
                                output logic [47:0] off, dly, output bit neg);
    logic [47:0] t [4];
    longint l [4];
    longint a, b;
    t[0] = t1; t[1] = t2; t[2] = t3; t[3] = t4;
    for (int i = 0; i < 4; i++)
      l[i] = (longint'(t[i][47:17]) * 125000 + longint'(t[i][16:0])) & 64'hFFFF_FFFF_FFFF;
    a = l[1] - l[0];
    b = l[3] - l[2];
    neg = (a + b) < 0;
    off = 48'((a - b) >>> 1);
    dly = 48'((a + b) >>> 1);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ev2(input logic [47:0] t);
    bus.timer = t; bus.ts_2_record = 1'b1; step(); bus.ts_2_record = 1'b0;
  endtask
  task automatic ev1(input logic [47:0] t);
    bus.ts_1 = t; bus.ts_1_valid = 1'b1; step(); bus.ts_1_valid = 1'b0;
  endtask
  task automatic ev3(input logic [47:0] t);
    bus.timer = t; bus.ts_3_record = 1'b1; step(); bus.ts_3_record = 1'b0;
  endtask
  task automatic ev4(input logic [47:0] t);
    bus.ts_4 = t; bus.ts_4_valid = 1'b1; step(); bus.ts_4_valid = 1'b0;
  endtask
  task automatic exchange(input logic [47:0] t1, t2, t3, t4);
    ev2(t2); ev1(t1); ev3(t3); ev4(t4);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    total++; if (bus.offset_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", bus.offset_valid); else passed++;
    total++; if (bus.sync_err !== 1'b0) $display("FAIL reset_err got %0b exp 0", bus.sync_err); else passed++;
    total++; if (bus.offset !== 48'd0) $display("FAIL reset_offset got %h exp 0", bus.offset); else passed++;
    total++; if (bus.delay !== 48'd0) $display("FAIL reset_delay got %h exp 0", bus.delay); else passed++;
    total++; if (bus.sync_count !== 32'd0) $display("FAIL reset_count got %0d exp 0", bus.sync_count); else passed++;
    reset = 1'b0;
    step();
  endtask
  task automatic test_basic();
    exchange(ts(10, 1000), ts(10, 1500), ts(10, 3000), ts(10, 3300));
    step();
    total++; if (bus.offset_valid !== 1'b0) $display("FAIL basic_early1 got %0b exp 0", bus.offset_valid); else passed++;
    step();
    total++; if (bus.offset_valid !== 1'b0) $display("FAIL basic_early2 got %0b exp 0", bus.offset_valid); else passed++;
    step();
    total++; if (bus.offset_valid !== 1'b1) $display("FAIL basic_valid got %0b exp 1", bus.offset_valid); else passed++;
    total++; if (bus.offset !== 48'd100) $display("FAIL basic_offset got %0d exp 100", bus.offset); else passed++;
    total++; if (bus.delay !== 48'd400) $display("FAIL basic_delay got %0d exp 400", bus.delay); else passed++;
    total++; if (bus.sync_count !== 32'd1) $display("FAIL basic_count got %0d exp 1", bus.sync_count); else passed++;
    step();
    total++; if (bus.offset_valid !== 1'b0) $display("FAIL basic_pulse got %0b exp 0", bus.offset_valid); else passed++;
  endtask
  task automatic test_wrap();
    exchange(ts(10, 124900), ts(11, 100), ts(11, 500), ts(11, 700));
    step(); step(); step();
    total++; if (bus.offset_valid !== 1'b1) $display("FAIL wrap_valid got %0b exp 1", bus.offset_valid); else passed++;
    total++; if (bus.offset !== 48'd0) $display("FAIL wrap_offset got %0d exp 0", bus.offset); else passed++;
    total++; if (bus.delay !== 48'd200) $display("FAIL wrap_delay got %0d exp 200", bus.delay); else passed++;
  endtask
  task automatic test_negative();
    exchange(ts(5, 0), ts(5, 100), ts(5, 1000), ts(5, 1300));
    step(); step(); step();
    total++; if (bus.offset_valid !== 1'b1) $display("FAIL neg_valid got %0b exp 1", bus.offset_valid); else passed++;
    total++; if (bus.offset !== 48'hFFFF_FFFF_FF9C) $display("FAIL neg_offset got %h exp ffffffffff9c", bus.offset); else passed++;
    total++; if (bus.delay !== 48'd200) $display("FAIL neg_delay got %0d exp 200", bus.delay); else passed++;
    exchange(ts(5, 0), ts(5, 101), ts(6, 0), ts(6, 0));
    step(); step(); step();
    total++; if (bus.offset_valid !== 1'b1) $display("FAIL floor_valid got %0b exp 1", bus.offset_valid); else passed++;
    total++; if (bus.offset !== 48'd50) $display("FAIL floor_offset got %0d exp 50", bus.offset); else passed++;
    total++; if (bus.delay !== 48'd50) $display("FAIL floor_delay got %0d exp 50", bus.delay); else passed++;
  endtask
  task automatic test_neg_delay();
    exchange(ts(5, 0), ts(5, 100), ts(5, 1300), ts(5, 1000));
    step(); step(); step();
    total++; if (bus.sync_err !== 1'b1) $display("FAIL negdly_err got %0b exp 1", bus.sync_err); else passed++;
    total++; if (bus.offset_valid !== 1'b0) $display("FAIL negdly_valid got %0b exp 0", bus.offset_valid); else passed++;
    total++; if (bus.offset !== 48'd50) $display("FAIL negdly_offset got %0d exp 50", bus.offset); else passed++;
    total++; if (bus.delay !== 48'd50) $display("FAIL negdly_delay got %0d exp 50", bus.delay); else passed++;
    total++; if (bus.sync_count !== 32'd4) $display("FAIL negdly_count got %0d exp 4", bus.sync_count); else passed++;
    step();
    total++; if (bus.sync_err !== 1'b0) $display("FAIL negdly_pulse got %0b exp 0", bus.sync_err); else passed++;
  endtask
  task automatic test_timeout();
    int k;
    bit seen;
    ev2(ts(1, 0));
    ev1(ts(1, 0));
    k = 0;
    while (k < TO + 10 && bus.sync_err !== 1'b1) begin
      step();
      k++;
    end
    total++; if (k !== TO) $display("FAIL timeout_cycles got %0d exp %0d", k, TO); else passed++;
    ev3(ts(1, 5));
    ev4(ts(1, 9));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen |= bus.offset_valid | bus.sync_err;
    end
    total++; if (seen !== 1'b0) $display("FAIL timeout_idle got %0b exp 0", seen); else passed++;
  endtask
  task automatic test_resync();
    ev2(ts(2, 0)); ev1(ts(2, 50)); ev3(ts(2, 500));
    ev2(ts(2, 900));
    total++; if (bus.sync_err !== 1'b1) $display("FAIL resync_err got %0b exp 1", bus.sync_err); else passed++;
    ev1(ts(2, 100));
    total++; if (bus.sync_err !== 1'b0) $display("FAIL resync_pulse got %0b exp 0", bus.sync_err); else passed++;
    ev3(ts(2, 2000)); ev4(ts(2, 2600));
    step(); step(); step();
    total++; if (bus.offset_valid !== 1'b1) $display("FAIL resync_valid got %0b exp 1", bus.offset_valid); else passed++;
    total++; if (bus.offset !== 48'd100) $display("FAIL resync_offset got %0d exp 100", bus.offset); else passed++;
    total++; if (bus.delay !== 48'd700) $display("FAIL resync_delay got %0d exp 700", bus.delay); else passed++;
    total++; if (bus.sync_count !== 32'd5) $display("FAIL resync_count got %0d exp 5", bus.sync_count); else passed++;
  endtask
  task automatic test_overlap();
    ev2(ts(3, 0)); ev1(ts(2, 124000)); ev3(ts(3, 5000));
    bus.ts_4 = ts(3, 5400); bus.ts_4_valid = 1'b1;
    bus.timer = ts(3, 9000); bus.ts_2_record = 1'b1;
    step();
    bus.ts_4_valid = 1'b0; bus.ts_2_record = 1'b0;
    total++; if (bus.sync_err !== 1'b0) $display("FAIL overlap_noerr got %0b exp 0", bus.sync_err); else passed++;
    ev1(ts(3, 8800)); ev3(ts(3, 20000)); ev4(ts(3, 20100));
    total++; if (bus.offset_valid !== 1'b1) $display("FAIL overlap1_valid got %0b exp 1", bus.offset_valid); else passed++;
    total++; if (bus.offset !== 48'd300) $display("FAIL overlap1_offset got %0d exp 300", bus.offset); else passed++;
    total++; if (bus.delay !== 48'd700) $display("FAIL overlap1_delay got %0d exp 700", bus.delay); else passed++;
    step(); step(); step();
    total++; if (bus.offset_valid !== 1'b1) $display("FAIL overlap2_valid got %0b exp 1", bus.offset_valid); else passed++;
    total++; if (bus.offset !== 48'd50) $display("FAIL overlap2_offset got %0d exp 50", bus.offset); else passed++;
    total++; if (bus.delay !== 48'd150) $display("FAIL overlap2_delay got %0d exp 150", bus.delay); else passed++;
    total++; if (bus.sync_count !== 32'd7) $display("FAIL overlap2_count got %0d exp 7", bus.sync_count); else passed++;
  endtask
  task automatic test_back_to_back();
    logic [47:0] t1, t2, t3, t4, n2, po, pd, exp_off, exp_dly;
    logic [31:0] exp_cnt;
    bit pn;
    exp_off = 48'd50; exp_dly = 48'd150; exp_cnt = 32'd7;
    po = '0; pd = '0; pn = 1'b0;
    t2 = rnd_ts(0);
    ev2(t2);
    for (int i = 0; i <= 24; i++) begin
      t1 = rnd_ts(i); t3 = rnd_ts(i); t4 = rnd_ts(i); n2 = rnd_ts(i + 1);
      if (i < 24) begin
        ev1(t1); ev3(t3);
        bus.ts_4 = t4; bus.ts_4_valid = 1'b1;
        if (i < 23) begin bus.timer = n2; bus.ts_2_record = 1'b1; end
        step();
        bus.ts_4_valid = 1'b0; bus.ts_2_record = 1'b0;
      end else begin
        step(); step(); step();
      end
      if (i > 0) begin
        if (pn) begin
          total++; if (bus.sync_err !== 1'b1) $display("FAIL rnd%0d_err got %0b exp 1", i, bus.sync_err); else passed++;
          total++; if (bus.offset_valid !== 1'b0) $display("FAIL rnd%0d_valid got %0b exp 0", i, bus.offset_valid); else passed++;
        end else begin
          exp_off = po; exp_dly = pd; exp_cnt++;
          total++; if (bus.offset_valid !== 1'b1) $display("FAIL rnd%0d_valid got %0b exp 1", i, bus.offset_valid); else passed++;
        end
        total++; if (bus.offset !== exp_off) $display("FAIL rnd%0d_offset got %h exp %h", i, bus.offset, exp_off); else passed++;
        total++; if (bus.delay !== exp_dly) $display("FAIL rnd%0d_delay got %h exp %h", i, bus.delay, exp_dly); else passed++;
        total++; if (bus.sync_count !== exp_cnt) $display("FAIL rnd%0d_count got %0d exp %0d", i, bus.sync_count, exp_cnt); else passed++;
      end
      if (i < 24) begin
        model(t1, t2, t3, t4, po, pd, pn);
        t2 = n2;
      end
    end
  endtask
  task automatic test_reset_inflight();
    bit seen;
    exchange(ts(10, 1000), ts(10, 1500), ts(10, 3000), ts(10, 3300));
    step();
    reset = 1'b1;
    #1;
    total++; if (bus.offset !== 48'd0) $display("FAIL rstfl_offset got %h exp 0", bus.offset); else passed++;
    total++; if (bus.delay !== 48'd0) $display("FAIL rstfl_delay got %h exp 0", bus.delay); else passed++;
    total++; if (bus.sync_count !== 32'd0) $display("FAIL rstfl_count got %0d exp 0", bus.sync_count); else passed++;
    step(); step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= bus.offset_valid | bus.sync_err;
    end
    total++; if (seen !== 1'b0) $display("FAIL rstfl_quiet got %0b exp 0", seen); else passed++;
    total++; if (bus.sync_count !== 32'd0) $display("FAIL rstfl_count_after got %0d exp 0", bus.sync_count); else passed++;
  endtask
  initial begin
    bus.timer = '0; bus.ts_1 = '0; bus.ts_4 = '0;
    bus.ts_2_record = 1'b0; bus.ts_1_valid = 1'b0; bus.ts_3_record = 1'b0; bus.ts_4_valid = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_negative();
    test_neg_delay();
    test_timeout();
    test_resync();
    test_overlap();
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
